// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the instruction-fetch / load-store memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE_WAIT = 2'd1,
        ST_BUSY       = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LSB  = 2'd2
    } owner_e;

    localparam logic [1:0] WT_BYTE         = 2'b00;
    localparam logic [1:0] WT_HALF         = 2'b01;
    localparam logic [1:0] WT_WORD         = 2'b10;
    localparam int         WT_UNSIGNED_BIT = 2;

    // Fetches are always a signed word read.
    localparam logic [2:0] WT_FETCH = {1'b0, WT_WORD};

    function automatic logic is_io_region(input logic [1:0] addr_hi, input logic [1:0] io_sel);
        return addr_hi == io_sel;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, control and memory-controller signals of the arbiter
interface mem_arbiter_if;
    logic        rdy_in;
    logic        rob_clear;
    logic        io_buffer_full;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;

    logic        lsb_req;
    logic        lsb_is_write;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic [2:0]  lsb_type;
    logic        lsb_ready;
    logic [31:0] lsb_rdata;

    logic        mc_new_task;
    logic        mc_is_write;
    logic [31:0] mc_addr;
    logic [31:0] mc_data_in;
    logic [2:0]  mc_work_type;
    logic [31:0] mc_data_out;
    logic        mc_ready;
    logic        mc_working;

    modport slave (
        input  rdy_in, rob_clear, io_buffer_full,
        input  if_req, if_addr,
        output if_ready, if_data,
        input  lsb_req, lsb_is_write, lsb_addr, lsb_wdata, lsb_type,
        output lsb_ready, lsb_rdata,
        output mc_new_task, mc_is_write, mc_addr, mc_data_in, mc_work_type,
        input  mc_data_out, mc_ready, mc_working
    );

    modport master (
        output rdy_in, rob_clear, io_buffer_full,
        output if_req, if_addr,
        input  if_ready, if_data,
        output lsb_req, lsb_is_write, lsb_addr, lsb_wdata, lsb_type,
        input  lsb_ready, lsb_rdata,
        input  mc_new_task, mc_is_write, mc_addr, mc_data_in, mc_work_type,
        output mc_data_out, mc_ready, mc_working
    );
endinterface

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - two-way round-robin choice between fetch and load/store requesters
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   i_if_cand,
    input  logic   i_lsb_cand,
    input  owner_e i_last_grant,
    output owner_e o_grant
);

    always_comb begin
        o_grant = OWN_NONE;
        if (i_if_cand && i_lsb_cand) begin
            o_grant = (i_last_grant == OWN_LSB) ? OWN_IF : OWN_LSB;
        end else if (i_if_cand) begin
            o_grant = OWN_IF;
        end else if (i_lsb_cand) begin
            o_grant = OWN_LSB;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding-task arbiter between fetch and load/store units
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic            clk_in,
    input  logic            rst_in,
    mem_arbiter_if.slave    bus
);

    arb_state_e  r_state;
    arb_state_e  w_state_nxt;
    owner_e      r_owner;
    owner_e      r_last_grant;
    owner_e      w_grant;
    logic        r_is_write;
    logic        r_if_ready;
    logic        r_lsb_ready;
    logic [31:0] r_if_data;
    logic [31:0] r_lsb_rdata;

    logic        w_lsb_io_block;
    logic        w_if_cand;
    logic        w_lsb_cand;
    logic        w_issue;
    logic        w_rd_done;
    logic        w_rd_drop;
    logic        w_wr_done;
    logic        w_done;

    logic        w_mc_new_task;
    logic        w_mc_is_write;
    logic [31:0] w_mc_addr;
    logic [31:0] w_mc_data_in;
    logic [2:0]  w_mc_work_type;

    assign w_lsb_io_block = bus.lsb_is_write && bus.io_buffer_full
                          && is_io_region(bus.lsb_addr[17:16], IO_SEL);

    // A requester whose ready pulse is out this cycle has not yet dropped its
    // request; masking it prevents a duplicate issue of the same access.
    assign w_if_cand  = bus.if_req  && !r_if_ready;
    assign w_lsb_cand = bus.lsb_req && !r_lsb_ready && !w_lsb_io_block;

    mem_arb_pick u_pick (
        .i_if_cand    (w_if_cand),
        .i_lsb_cand   (w_lsb_cand),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_issue = rst_in && bus.rdy_in && !bus.rob_clear
                   && (r_state == ST_IDLE) && (w_grant != OWN_NONE);

    // Flushed reads are dropped; stores already sent must still be acknowledged.
    assign w_rd_drop = !r_is_write && bus.rob_clear
                     && ((r_state == ST_ISSUE_WAIT) || (r_state == ST_BUSY));
    assign w_rd_done = (r_state == ST_BUSY) && !r_is_write && bus.mc_ready && !bus.rob_clear;
    assign w_wr_done = (r_state == ST_BUSY) && r_is_write && !bus.mc_working;
    assign w_done    = w_rd_done || w_rd_drop || w_wr_done;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else if (bus.rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = ST_ISSUE_WAIT;
                end
            end
            ST_ISSUE_WAIT: begin
                w_state_nxt = w_rd_drop ? ST_IDLE : ST_BUSY;
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mc_new_task  = 1'b0;
        w_mc_is_write  = 1'b0;
        w_mc_addr      = 32'd0;
        w_mc_data_in   = 32'd0;
        w_mc_work_type = 3'd0;
        if (w_issue) begin
            w_mc_new_task = 1'b1;
            if (w_grant == OWN_LSB) begin
                w_mc_is_write  = bus.lsb_is_write;
                w_mc_addr      = bus.lsb_addr;
                w_mc_data_in   = bus.lsb_wdata;
                w_mc_work_type = bus.lsb_type;
            end else begin
                w_mc_addr      = bus.if_addr;
                w_mc_work_type = WT_FETCH;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_owner      <= OWN_NONE;
            r_last_grant <= OWN_IF;
            r_is_write   <= 1'b0;
            r_if_ready   <= 1'b0;
            r_lsb_ready  <= 1'b0;
            r_if_data    <= 32'd0;
            r_lsb_rdata  <= 32'd0;
        end else if (bus.rdy_in) begin
            r_if_ready  <= 1'b0;
            r_lsb_ready <= 1'b0;
            if (w_issue) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_is_write   <= (w_grant == OWN_LSB) && bus.lsb_is_write;
            end
            if (w_rd_done) begin
                if (r_owner == OWN_LSB) begin
                    r_lsb_ready <= 1'b1;
                    r_lsb_rdata <= bus.mc_data_out;
                end else begin
                    r_if_ready  <= 1'b1;
                    r_if_data   <= bus.mc_data_out;
                end
            end
            if (w_wr_done) begin
                r_lsb_ready <= 1'b1;
            end
            if (w_done) begin
                r_owner    <= OWN_NONE;
                r_is_write <= 1'b0;
            end
        end
    end

    assign bus.mc_new_task  = w_mc_new_task;
    assign bus.mc_is_write  = w_mc_is_write;
    assign bus.mc_addr      = w_mc_addr;
    assign bus.mc_data_in   = w_mc_data_in;
    assign bus.mc_work_type = w_mc_work_type;
    assign bus.if_ready     = r_if_ready;
    assign bus.if_data      = r_if_data;
    assign bus.lsb_ready    = r_lsb_ready;
    assign bus.lsb_rdata    = r_lsb_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter IO_SEL, default 2'b11; addr[17:16] value marking the I/O region.
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  asynchronous, active-low reset.
REQ-004 rdy_in  input  1  global ready; low freezes all state, outputs hold.
REQ-005 rob_clear  input  1  pipeline flush.
REQ-006 io_buffer_full  input  1  UART buffer full.
REQ-007 if_req  input  1  fetch request; held high until if_ready.
REQ-008 if_addr  input  32  fetch address; always a signed word read, type 3'b010.
REQ-009 if_ready  output  1  one-cycle pulse; if_data valid.
REQ-010 if_data  output  32  fetched word.
REQ-011 lsb_req  input  1  load/store request; held until lsb_ready.
REQ-012 lsb_is_write  input  1  1 = store.
REQ-013 lsb_addr  input  32  load/store address.
REQ-014 lsb_wdata  input  32  store data.
REQ-015 lsb_type  input  3  [2] unsigned, [1:0] 00 byte / 01 half / 10 word.
REQ-016 lsb_ready  output  1  one-cycle pulse; load data valid or store done.
REQ-017 lsb_rdata  output  32  load result.
REQ-018 mc_new_task, mc_is_write  output  1 each  task strobe and direction to the memory controller.
REQ-019 mc_addr, mc_data_in  output  32 each  task address and store data.
REQ-020 mc_work_type  output  3  task type.
REQ-021 mc_data_out  input  32  controller result.
REQ-022 mc_ready  input  1  read-complete pulse.
REQ-023 mc_working  input  1  controller busy.

Function
REQ-024 FSM states: IDLE, ISSUE_WAIT, BUSY; owner register: NONE, IF, LSB.
REQ-025 In IDLE with rdy_in high and a request pending, mc_new_task SHALL assert combinationally for one cycle with the winner's fields; state moves to ISSUE_WAIT.
REQ-026 Arbitration: if only one requester pending, it wins; if both, the one not granted last wins (last_grant register, reset = IF, so LSB wins first tie).
REQ-027 An LSB store with addr[17:16]==IO_SEL SHALL NOT be issued while io_buffer_full is high; the pending fetch may be issued instead.
REQ-028 ISSUE_WAIT lasts exactly one cycle (controller status is registered), then BUSY.
REQ-029 BUSY, read owner: completes on the cycle mc_ready is high; mc_data_out is copied to if_data/lsb_rdata, matching ready pulses the same cycle; state returns to IDLE.
REQ-030 BUSY, write owner: completes on the first cycle mc_working is low; lsb_ready pulses; state returns to IDLE.
REQ-031 No new task is issued in the cycle a completion is detected; minimum issue-to-issue spacing is 3 cycles.
REQ-032 mc_new_task SHALL never assert outside IDLE.
REQ-033 rob_clear high with a read in ISSUE_WAIT/BUSY: drop the transaction, no ready pulse, return to IDLE.
REQ-034 rob_clear high with a store in flight: store completes normally and lsb_ready still pulses.
REQ-035 rob_clear high in IDLE: no task issued that cycle, including stores.
REQ-036 if_ready and lsb_ready are never both high in one cycle.
REQ-037 Request drop before grant is legal and leaves no state.

Reset
REQ-038 rst_in low: state = IDLE, owner = NONE, last_grant = IF, if_ready = lsb_ready = 0, if_data = lsb_rdata = 0; mc_new_task low during and after reset.
REQ-039 Reset mid-transaction abandons it without any ready pulse.

Structure
REQ-040 State encodings, owner encodings, and work-type constants (BYTE, HALF, WORD, unsigned bit) SHALL reside in the shared CPU defines package.
REQ-041 Single module; the arbitration choice may be a small combinational sub-module, mem_arb_pick.

Verification
REQ-042 if_req only, addr 0x100, memory word 0xDEADBEEF -> one task type 3'b010; if_ready with if_data = 0xDEADBEEF.
REQ-043 if_req and lsb_req (load byte 0x200, value 0x80, type 000) together from reset -> LSB served first, lsb_rdata = 0xFFFFFF80; then fetch served.
REQ-044 Store word 0x12345678 to 0x300 -> lsb_ready pulses on the first cycle after ISSUE_WAIT with mc_working low; readback returns 0x12345678.
REQ-045 Store to 0x30000 with io_buffer_full high for 10 cycles plus pending fetch -> fetch issued and completed; store issued only after io_buffer_full falls.
REQ-046 rob_clear during BUSY of a word load -> no lsb_ready, IDLE next cycle; rob_clear during a word store -> lsb_ready still pulses.
REQ-047 rdy_in low for 5 cycles mid-BUSY -> state and outputs frozen; completion occurs after rdy_in returns.
